// File: rtl/pll_reconfig_writer_if.sv
// Avalon-MM management bus between the PLL reconfig writer (master)
// and the PLL reconfiguration IP (slave).
interface pll_reconfig_writer_if;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address,
        output mgmt_writedata,
        output mgmt_write,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address,
        input  mgmt_writedata,
        input  mgmt_write,
        output mgmt_waitrequest
    );
endinterface

// File: rtl/pll_reconfig_writer.sv
// PLL reconfiguration writer: on start, latches a counter set, writes
// mode/N/M/C0/C1 and the reconfig start word over Avalon-MM, then waits
// for the PLL to re-lock (done) or times out (sticky error).
module pll_reconfig_writer #(
    parameter int            TW           = 22,
    parameter logic [TW-1:0] LOCK_TIMEOUT = 22'd2500000
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [17:0]           cfg_n,
    input  logic [17:0]           cfg_m,
    input  logic [17:0]           cfg_c0,
    input  logic [17:0]           cfg_c1,
    input  logic                  pll_locked,
    pll_reconfig_writer_if.master mgmt,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Write states are consecutive so that "next write" is state + 1,
    // and the state after WR_START is WAIT_LOCK.
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_MODE   = 4'd1;
    localparam logic [3:0] S_WR_N      = 4'd2;
    localparam logic [3:0] S_WR_M      = 4'd3;
    localparam logic [3:0] S_WR_C0     = 4'd4;
    localparam logic [3:0] S_WR_C1     = 4'd5;
    localparam logic [3:0] S_WR_START  = 4'd6;
    localparam logic [3:0] S_WAIT_LOCK = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;
    localparam logic [3:0] S_ERR       = 4'd9;

    // Ignore a lock seen this early: it is the stale pre-reconfig lock.
    localparam logic [TW-1:0] MIN_LOCK_WAIT = TW'(16);

    logic [3:0]    state_q, state_d;
    logic          write_q, write_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [1:0]    locked_sync_q;
    logic [17:0]   n_q, m_q, c0_q, c1_q;
    logic          load_cfg;
    logic [5:0]    address;
    logic [31:0]   writedata;

    // Next-state logic. Inside a write state, write_q doubles as the phase
    // bit: high = transaction in flight, low = the one idle cycle before
    // moving on to the next write.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d  = state_q;
        write_d  = write_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        cnt_d    = '0;
        load_cfg = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_cfg = 1'b1;
                    state_d  = S_WR_MODE;
                    write_d  = 1'b1;
                    busy_d   = 1'b1;
                    error_d  = 1'b0;
                end
            end
            S_WR_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_C1, S_WR_START: begin
                if (write_q) begin
                    if (!mgmt.mgmt_waitrequest) begin
                        write_d = 1'b0;
                    end
                end else begin
                    state_d = state_q + 4'd1;
                    write_d = (state_q != S_WR_START);
                end
            end
            S_WAIT_LOCK: begin
                cnt_d = cnt_q + TW'(1);
                if (locked_sync_q[1] && (cnt_q >= MIN_LOCK_WAIT)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (cnt_q == LOCK_TIMEOUT - TW'(1)) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                write_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state registers and the pll_locked double synchroniser.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            write_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            cnt_q         <= '0;
            locked_sync_q <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            write_q       <= write_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            cnt_q         <= cnt_d;
            locked_sync_q <= {locked_sync_q[0], pll_locked};
        end
    end

    // Shadow copy of the counter set, captured only when a start is accepted.
    always_ff @(posedge refclk or posedge rst) begin
        // NOTE: the shadows are cleared on reset so the write data is never X,
        // even though they are always reloaded before being used.
        if (rst) begin
            n_q  <= '0;
            m_q  <= '0;
            c0_q <= '0;
            c1_q <= '0;
        end else if (load_cfg) begin
            n_q  <= cfg_n;
            m_q  <= cfg_m;
            c0_q <= cfg_c0;
            c1_q <= cfg_c1;
        end
    end

    // Register map of the PLL reconfig IP: fixed address/data per write state.
    always_comb begin
        address   = 6'h00;
        writedata = 32'h0000_0000;
        case (state_q)
            S_WR_MODE:  begin address = 6'h00; writedata = 32'h0000_0000;           end
            S_WR_N:     begin address = 6'h03; writedata = {14'b0, n_q};            end
            S_WR_M:     begin address = 6'h04; writedata = {14'b0, m_q};            end
            S_WR_C0:    begin address = 6'h05; writedata = {9'b0, 5'd0, c0_q};      end
            S_WR_C1:    begin address = 6'h05; writedata = {9'b0, 5'd1, c1_q};      end
            S_WR_START: begin address = 6'h02; writedata = 32'h0000_0001;           end
            default:    begin address = 6'h00; writedata = 32'h0000_0000;           end
        endcase
    end

    assign mgmt.mgmt_address   = address;
    assign mgmt.mgmt_writedata = writedata;
    assign mgmt.mgmt_write     = write_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;

endmodule
